mux_rr_nx1: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with a registered output stage and a valid/ready handshake on every channel.
- Two selection modes:
  - Direct: an external ctrl index picks the channel, as the earlier fixed 6x1 combinational mux did.
  - Round-robin: the block scans valid channels fairly.
- Sits between multiple producer streams and a single consumer; one transfer per cycle at most.

---
 rtl/mux_rr_nx1.sv | 125 ++++++++++++
 tb/tb_mux_rr_nx1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1 : N-input, WIDTH-bit selector with a registered output stage and
// valid/ready handshakes. Direct mode picks the channel from ctrl; round-robin
// mode scans valid channels starting at a rotating pointer.
// Optional build macro MUX_GRANT_CNT_EN adds a saturating 16-bit transfer
// counter on output port grant_cnt.
module mux_rr_nx1 #(
  parameter  int WIDTH = 8,
  parameter  int N     = 6,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     ctrl,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
`ifdef MUX_GRANT_CNT_EN
  ,
  output logic [15:0]          grant_cnt
`endif
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic             w_hi_found, w_lo_found, w_dir_grant;
  logic [SEL_W-1:0] w_hi_idx, w_lo_idx;
  logic [SEL_W-1:0] w_cand;
  logic             w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_cand_data;

  assign w_load = !r_out_valid || out_ready;

  // Scan channels: lowest valid at/after ptr, lowest valid before ptr (wrap),
  // and whether the direct index hits a valid channel (ctrl>=N never matches).
  always_comb begin
    w_hi_found  = 1'b0;
    w_hi_idx    = '0;
    w_lo_found  = 1'b0;
    w_lo_idx    = '0;
    w_dir_grant = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) >= r_ptr)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = SEL_W'(i);
      end
      if (in_valid[i] && (SEL_W'(i) < r_ptr)) begin
        w_lo_found = 1'b1;
        w_lo_idx   = SEL_W'(i);
      end
      if (in_valid[i] && (SEL_W'(i) == ctrl))
        w_dir_grant = 1'b1;
    end
  end

  assign w_cand  = mode ? (w_hi_found ? w_hi_idx : w_lo_idx) : ctrl;
  assign w_grant = mode ? (w_hi_found || w_lo_found) : w_dir_grant;
  assign w_xfer  = rst_n && w_load && w_grant;

  // Fetch the candidate's data without a variable part-select that could run
  // past the bus when ctrl is out of range.
  always_comb begin
    w_cand_data = '0;
    for (int i = 0; i < N; i++)
      if (w_cand == SEL_W'(i))
        w_cand_data = in_data[i*WIDTH +: WIDTH];
  end

  // One-hot ready toward the granted channel only, silent during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = w_xfer && (w_cand == SEL_W'(i));
  end

  // Output register and round-robin pointer; ptr only moves on RR transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_data  <= w_cand_data;
        r_out_sel   <= w_cand;
        r_out_valid <= 1'b1;
        if (mode)
          r_ptr <= (w_cand == LAST) ? '0 : w_cand + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

`ifdef MUX_GRANT_CNT_EN
  logic [15:0] r_grant_cnt;

  // Saturating count of input transfers.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_grant_cnt <= '0;
    else if (w_xfer && (r_grant_cnt != 16'hFFFF))
      r_grant_cnt <= r_grant_cnt + 16'd1;
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1 : directed test-plan sequence with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_mux_rr_nx1;
  localparam int WIDTH = 8;
  localparam int N     = 6;
  localparam int SEL_W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   ctrl;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_sel;
`ifdef MUX_GRANT_CNT_EN
  logic [15:0]        grant_cnt;
`endif

  mux_rr_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .ctrl(ctrl), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
`ifdef MUX_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_init = 0;
  bit       m_valid;
  int       m_data, m_sel, m_ptr, m_cnt;

  // Inputs change only just after posedge, so at negedge they are exactly what
  // the next posedge will sample: check current state, then advance the model.
  always @(negedge clk) begin
    int  cand;
    bit  grant, load;
    logic [N-1:0] exp_rdy;
    cand = 0; grant = 0;
    load = !m_valid || out_ready;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!grant && in_valid[j]) begin grant = 1; cand = j; end
      end
    end else begin
      cand  = int'(ctrl);
      grant = (cand < N) && in_valid[cand % N];
    end
    exp_rdy = '0;
    if (rst_n && load && grant) exp_rdy[cand] = 1'b1;

    if (m_init) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_data",  32'(out_data),  32'(m_data));
      chk("m_out_sel",   32'(out_sel),   32'(m_sel));
      chk("m_in_ready",  32'(in_ready),  32'(exp_rdy));
`ifdef MUX_GRANT_CNT_EN
      chk("m_grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
    end

    if (!rst_n) begin
      m_init = 1; m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_init && load) begin
      if (grant) begin
        m_valid = 1;
        m_data  = int'(in_data[cand*WIDTH +: WIDTH]);
        m_sel   = cand;
        if (mode) m_ptr = (cand + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_valid = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; mode = 0; ctrl = 0; out_ready = 1; in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);

    // Reset held two cycles with every channel valid.
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_sel",   32'(out_sel),   0);
    chk("rst_in_ready",  32'(in_ready),  0);
    rst_n = 1;

    // Direct sweep.
    for (int c = 0; c < N; c++) begin
      ctrl = SEL_W'(c);
      cyc();
      chk("dir_out_sel",   32'(out_sel),   32'(c));
      chk("dir_out_data",  32'(out_data),  32'(c));
      chk("dir_out_valid", 32'(out_valid), 1);
    end

    // Out-of-range direct index: no grant, output drains.
    ctrl = 3'b110; #1;
    chk("dir6_in_ready", 32'(in_ready), 0);
    cyc();
    chk("dir6_out_valid", 32'(out_valid), 0);
    ctrl = 3'b111; #1;
    chk("dir7_in_ready", 32'(in_ready), 0);
    cyc();
    chk("dir7_out_valid", 32'(out_valid), 0);

    // Round-robin with every channel valid; ptr still 0.
    mode = 1; ctrl = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_all_sel", 32'(out_sel), 32'(k % N));
    end
    // ptr is 2 now; only channels 2 and 5 valid.
    in_valid = 6'b100100;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_pair_sel", 32'(out_sel), (k % 2 == 0) ? 2 : 5);
    end

    // Backpressure: stream 0..3 then stall on word 3.
    in_valid = '1;
    for (int k = 0; k < 4; k++) cyc();
    chk("bp_pre_data", 32'(out_data), 3);
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp_hold_data",  32'(out_data),  3);
      chk("bp_hold_sel",   32'(out_sel),   3);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready",   32'(in_ready),  0);
    end
    out_ready = 1;
    cyc();
    chk("bp_release_sel", 32'(out_sel), 4);

    // Reset mid-stream, then ten transfers from channel 0.
    cyc();
    rst_n = 0; #1;
    chk("mrst_in_ready", 32'(in_ready), 0);
    cyc();
    chk("mrst_out_valid", 32'(out_valid), 0);
`ifdef MUX_GRANT_CNT_EN
    chk("mrst_grant_cnt", 32'(grant_cnt), 0);
`endif
    rst_n = 1;
    cyc();
    chk("mrst_first_sel", 32'(out_sel), 0);
    for (int k = 1; k < 10; k++) cyc();
    chk("mrst_tenth_sel", 32'(out_sel), 3);
`ifdef MUX_GRANT_CNT_EN
    chk("cnt_ten", 32'(grant_cnt), 10);
`endif

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      in_valid  = N'($urandom);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      ctrl      = SEL_W'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 150) != 0);
      cyc();
    end
    rst_n = 1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
